// File: rtl/index_xfer_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : index_xfer_ctrl_if
// Description : Request handshake and register-bus strobes for the
//               index/transfer micro-op sequencer.
//               master : requester plus register/bus fabric. It drives the
//                        request fields and the current system bus value.
//               slave  : the sequencer. It drives the register strobes, the
//                        bus output, status and the N/Z flag results.
// Ports       : start, src_sel, dst_sel, op, flagUpdate_EN, systemBus_IN
//               (master -> slave); regWrite_EN, regRead_EN, busDrive_EN,
//               systemBus_OUT, busy, done, flagWrite_EN, flagN, flagZ
//               (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface index_xfer_ctrl_if #(
  parameter int NUM_REGS = 4,
  parameter int WIDTH    = 8
);
  localparam int SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  // request side
  logic                start;
  logic [SEL_W-1:0]    src_sel;
  logic [SEL_W-1:0]    dst_sel;
  logic [1:0]          op;
  logic                flagUpdate_EN;
  logic [WIDTH-1:0]    systemBus_IN;

  // sequencer outputs
  logic [NUM_REGS-1:0] regWrite_EN;
  logic [NUM_REGS-1:0] regRead_EN;
  logic                busDrive_EN;
  logic [WIDTH-1:0]    systemBus_OUT;
  logic                busy;
  logic                done;
  logic                flagWrite_EN;
  logic                flagN;
  logic                flagZ;

  modport master (
    output start, src_sel, dst_sel, op, flagUpdate_EN, systemBus_IN,
    input  regWrite_EN, regRead_EN, busDrive_EN, systemBus_OUT,
           busy, done, flagWrite_EN, flagN, flagZ
  );

  modport slave (
    input  start, src_sel, dst_sel, op, flagUpdate_EN, systemBus_IN,
    output regWrite_EN, regRead_EN, busDrive_EN, systemBus_OUT,
           busy, done, flagWrite_EN, flagN, flagZ
  );
endinterface
`default_nettype wire

// File: rtl/index_xfer_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : index_xfer_ctrl
// Description : Sequencer for the TAX/TAY/TXA/TYA/TSX/TXS/INX/INY/DEX/DEY
//               micro-ops. It reads the source register over the system bus,
//               applies MOVE/INC/DEC, drives the result back onto the bus
//               into the destination register and reports N/Z.
//               Sequence: IDLE -> DRIVE -> COMPUTE -> LATCH -> DONE -> IDLE.
// Ports       : clk  - system clock, rising edge
//               rst  - synchronous active-high reset
//               bus  - index_xfer_ctrl_if.slave (request, register strobes,
//                      bus data, status and flag results)
// Revision    : 1.0 - initial release
// ============================================================================
module index_xfer_ctrl #(
  parameter int NUM_REGS = 4,
  parameter int WIDTH    = 8
) (
  input  wire logic        clk,
  input  wire logic        rst,
  index_xfer_ctrl_if.slave bus
);

  localparam int SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [1:0] OP_INC = 2'd1;
  localparam logic [1:0] OP_DEC = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DRIVE   = 3'd1,
    S_COMPUTE = 3'd2,
    S_LATCH   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t state;
  state_t state_next;

  // captured request
  logic [SEL_W-1:0] req_src;
  logic [SEL_W-1:0] req_dst;
  logic [1:0]       req_op;
  logic             req_flag_upd;

  // datapath
  logic [WIDTH-1:0] temp;
  logic [WIDTH-1:0] result;
  logic             flag_n;
  logic             flag_z;

  // state decodes
  logic [NUM_REGS-1:0] reg_write_en;
  logic [NUM_REGS-1:0] reg_read_en;
  logic                bus_drive_en;
  logic [WIDTH-1:0]    bus_out;
  logic                busy_d;
  logic                done_d;
  logic                flag_write_d;

  function automatic logic [NUM_REGS-1:0] onehot(input logic [SEL_W-1:0] sel);
    logic [NUM_REGS-1:0] v;
    v = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and output decode. Every output depends only on the state and
  // on registered request/datapath values, so start never reaches an enable
  // combinationally.
  // --------------------------------------------------------------------------
  always_comb begin
    state_next   = state;
    reg_write_en = '0;
    reg_read_en  = '0;
    bus_drive_en = 1'b0;
    bus_out      = '0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    flag_write_d = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_next = S_DRIVE;
        end
      end
      S_DRIVE: begin
        busy_d       = 1'b1;
        reg_write_en = onehot(req_src);
        state_next   = S_COMPUTE;
      end
      S_COMPUTE: begin
        // Turnaround: source register has released the bus and this block
        // has not started driving yet.
        busy_d     = 1'b1;
        state_next = S_LATCH;
      end
      S_LATCH: begin
        busy_d       = 1'b1;
        bus_drive_en = 1'b1;
        bus_out      = result;
        reg_read_en  = onehot(req_dst);
        state_next   = S_DONE;
      end
      S_DONE: begin
        busy_d       = 1'b1;
        done_d       = 1'b1;
        flag_write_d = req_flag_upd;
        state_next   = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Request capture and datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      req_src      <= '0;
      req_dst      <= '0;
      req_op       <= '0;
      req_flag_upd <= 1'b0;
      temp         <= '0;
      result       <= '0;
      flag_n       <= 1'b0;
      flag_z       <= 1'b0;
    end else begin
      if (state == S_IDLE && bus.start) begin
        req_src      <= bus.src_sel;
        req_dst      <= bus.dst_sel;
        req_op       <= bus.op;
        req_flag_upd <= bus.flagUpdate_EN;
      end

      if (state == S_DRIVE) begin
        temp <= bus.systemBus_IN;
      end

      if (state == S_COMPUTE) begin
        // Reserved op code falls through to a plain move.
        case (req_op)
          OP_INC:  result <= temp + WIDTH'(1);
          OP_DEC:  result <= temp - WIDTH'(1);
          default: result <= temp;
        endcase
      end

      // Flags are loaded on entry to DONE and hold until the next DONE.
      if (state == S_LATCH) begin
        flag_n <= result[WIDTH-1];
        flag_z <= (result == '0);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.regWrite_EN   = reg_write_en;
  assign bus.regRead_EN    = reg_read_en;
  assign bus.busDrive_EN   = bus_drive_en;
  assign bus.systemBus_OUT = bus_out;
  assign bus.busy          = busy_d;
  assign bus.done          = done_d;
  assign bus.flagWrite_EN  = flag_write_d;
  assign bus.flagN         = flag_n;
  assign bus.flagZ         = flag_z;

  // --------------------------------------------------------------------------
  // Bus invariants
  // --------------------------------------------------------------------------
  a_no_bus_contention: assert property (@(posedge clk) disable iff (rst)
    !((|reg_write_en) && bus_drive_en));

  a_write_onehot0: assert property (@(posedge clk) disable iff (rst)
    $onehot0(reg_write_en));

  a_read_onehot0: assert property (@(posedge clk) disable iff (rst)
    $onehot0(reg_read_en));

  a_no_write_read_overlap: assert property (@(posedge clk) disable iff (rst)
    !((|reg_write_en) && (|reg_read_en)));

endmodule
`default_nettype wire
